dtcm_ctrl: RTL and testbench

Load/store front end for the data TCM. Accepts byte-addressed byte, half and word requests from the LSU over a valid/ready command channel. Drives the word-wide, byte-masked, single-port sim_ram directly downstream, and returns aligned, extended read data or a write acknowledge on a valid/ready response channel. It sustains one request per cycle and absorbs response backpressure with a one-entry hold register.

---
 rtl/dtcm_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_dtcm_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_ctrl.sv
// -----------------------------------------------------------------------------
// dtcm_ctrl
//
// Load/store front end for the data TCM. Takes byte/half/word requests from the
// LSU on a valid/ready command channel, drives a word-wide byte-masked
// single-port RAM, and returns aligned and extended load data (or a store
// acknowledge / error) on a valid/ready response channel. One request per cycle
// is sustained; response backpressure is absorbed by a one-entry hold register.
//
// Optional feature macro:
//   DTCM_CTRL_ALIGN_CHK_EN  - when defined, misaligned half/word accesses are
//                             rejected with rsp_err; when undefined, the low
//                             address bits that would cause misalignment are
//                             ignored (half uses addr[1], word uses offset 0).
//
// Parameters:
//   AW  byte address width of cmd_addr, width of ram_addr
//   DP  RAM depth in 32-bit words; word index >= DP is out of range
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cmd_valid      request present
//   cmd_ready      request accepted when cmd_valid & cmd_ready
//   cmd_read       1 = load, 0 = store
//   cmd_addr       byte address
//   cmd_size       0 byte, 1 half, 2 word, 3 reserved
//   cmd_unsigned   load zero-extends when 1, sign-extends when 0
//   cmd_wdata      store data, LSB-justified
//   rsp_valid      response present
//   rsp_ready      response consumed when rsp_valid & rsp_ready
//   rsp_rdata      load result; 0 for stores and errors
//   rsp_err        request rejected, RAM untouched
//   ram_addr       word index (cmd_addr[AW-1:2], zero-extended)
//   ram_din        replicated store data
//   ram_we         write strobe
//   ram_wem        byte write mask
//   ram_dout       RAM read data, valid the cycle after a non-write address
// -----------------------------------------------------------------------------
module dtcm_ctrl #(
   parameter int AW = 32,
   parameter int DP = 512
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_read,
   input  logic [AW-1:0] cmd_addr,
   input  logic [1:0]    cmd_size,
   input  logic          cmd_unsigned,
   input  logic [31:0]   cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_din,
   output logic          ram_we,
   output logic [3:0]    ram_wem,
   input  logic [31:0]   ram_dout
);

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   localparam logic [AW-1:0] DP_W = AW'(DP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRESH = 2'd1,
      ST_HELD  = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Byte lane actually used for the access. Low bits that would make the
   // access misaligned are dropped; with alignment checking enabled such
   // accesses are rejected before this offset matters.
   function automatic logic [1:0] eff_offset(input logic [1:0] addr_lo,
                                             input logic [1:0] size);
      logic [1:0] off;
      case (size)
         SZ_BYTE: off = addr_lo;
         SZ_HALF: off = {addr_lo[1], 1'b0};
         SZ_WORD: off = 2'b00;
         default: off = 2'b00;
      endcase
      return off;
   endfunction

   // Replicate store data across all lanes so the mask alone selects bytes.
   function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                              input logic [1:0]  size);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] store_mask(input logic [1:0] off,
                                             input logic [1:0] size);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = 4'b0011 << off;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Right-align the addressed lanes and sign/zero extend.
   function automatic logic [31:0] load_fmt(input logic [31:0] dout,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = dout >> {off, 3'b000};
      case (size)
         SZ_BYTE: r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
         SZ_HALF: r = uns ? {16'h0000,   sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [1:0]    off_q,   off_d;
   logic [1:0]    size_q,  size_d;
   logic          uns_q,   uns_d;
   logic          read_q,  read_d;
   logic          err_q,   err_d;
   logic [31:0]   hold_q,  hold_d;

   logic [AW-1:0] word_idx_s;
   logic [1:0]    cmd_off_s;
   logic          range_err_s;
   logic          align_err_s;
   logic          cmd_err_s;
   logic          acc_s;
   logic [31:0]   fmt_s;

   assign word_idx_s  = {2'b00, cmd_addr[AW-1:2]};
   assign cmd_off_s   = eff_offset(cmd_addr[1:0], cmd_size);
   assign range_err_s = (word_idx_s >= DP_W);

`ifdef DTCM_CTRL_ALIGN_CHK_EN
   assign align_err_s = ((cmd_size == SZ_HALF) && cmd_addr[0]) ||
                        ((cmd_size == SZ_WORD) && (cmd_addr[1:0] != 2'b00));
`else
   assign align_err_s = 1'b0;
`endif

   assign cmd_err_s = (cmd_size == SZ_RSVD) || range_err_s || align_err_s;

   assign rsp_valid = (state_q != ST_IDLE);
   assign cmd_ready = ~rst & (~rsp_valid | rsp_ready);
   assign acc_s     = cmd_valid & cmd_ready;

   // RAM side is driven straight from the command; only the strobe is gated.
   assign ram_addr = word_idx_s;
   assign ram_din  = store_data(cmd_wdata, cmd_size);
   assign ram_wem  = store_mask(cmd_off_s, cmd_size);
   assign ram_we   = acc_s & ~cmd_read & ~cmd_err_s;

   // Processed result of the pending request using live RAM data; stores and
   // errors always return zero.
   assign fmt_s = (read_q && !err_q) ? load_fmt(ram_dout, off_q, size_q, uns_q)
                                     : 32'h00000000;

   // ---------------------------------------------------------------------------
   // Response FSM
   // ---------------------------------------------------------------------------

   // Next-state, pending-request capture and hold register update.
   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      size_d  = size_q;
      uns_d   = uns_q;
      read_d  = read_q;
      err_d   = err_q;
      hold_d  = hold_q;

      case (state_q)
         ST_IDLE: begin
            if (acc_s) begin
               state_d = ST_FRESH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FRESH: begin
            // RAM output is only valid this cycle; keep a copy in case the
            // consumer stalls.
            hold_d = fmt_s;
            if (rsp_ready) begin
               state_d = acc_s ? ST_FRESH : ST_IDLE;
            end else begin
               state_d = ST_HELD;
            end
         end
         ST_HELD: begin
            if (rsp_ready) begin
               state_d = acc_s ? ST_FRESH : ST_IDLE;
            end else begin
               state_d = ST_HELD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (acc_s) begin
         off_d  = cmd_off_s;
         size_d = cmd_size;
         uns_d  = cmd_unsigned;
         read_d = cmd_read;
         err_d  = cmd_err_s;
      end else begin
         off_d  = off_q;
         size_d = size_q;
         uns_d  = uns_q;
         read_d = read_q;
         err_d  = err_q;
      end
   end

   // State, pending-request fields and hold register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         off_q   <= 2'b00;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         read_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 32'h00000000;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         read_q  <= read_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
      end
   end

   // Response data source: live RAM on the first cycle, hold register after.
   always_comb begin
      rsp_rdata = 32'h00000000;
      case (state_q)
         ST_FRESH: rsp_rdata = fmt_s;
         ST_HELD:  rsp_rdata = hold_q;
         default:  rsp_rdata = 32'h00000000;
      endcase
   end

   assign rsp_err = rsp_valid & err_q;

endmodule

// File: tb/tb_dtcm_ctrl.sv
module tb_dtcm_ctrl;

   localparam int AW = 32;
   localparam int DP = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_read;
   logic [AW-1:0] cmd_addr;
   logic [1:0]    cmd_size;
   logic          cmd_unsigned;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic          ram_we;
   logic [3:0]    ram_wem;
   logic [31:0]   ram_dout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dtcm_ctrl #(.AW(AW), .DP(DP)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_read     (cmd_read),
      .cmd_addr     (cmd_addr),
      .cmd_size     (cmd_size),
      .cmd_unsigned (cmd_unsigned),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_we       (ram_we),
      .ram_wem      (ram_wem),
      .ram_dout     (ram_dout)
   );

   // Behavioural single-port RAM: masked write, or registered read of the
   // presented address on every non-write cycle.
   logic [31:0] mem [0:DP-1];
   logic        ram_init_done = 1'b0;

   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < DP; i++) mem[i] <= 32'hC0DE0000 + i;
         mem[0] <= 32'h11223344;
         mem[1] <= 32'h55667788;
         mem[2] <= 32'h99AABBCC;
         ram_init_done <= 1'b1;
         ram_dout <= 32'h00000000;
      end else if (ram_we) begin
         if (ram_addr < DP) begin
            for (int b = 0; b < 4; b++)
               if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
         end
      end else begin
         ram_dout <= (ram_addr < DP) ? mem[ram_addr[8:0]] : 32'h00000000;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Issue one request with rsp_ready=1; called #1 after a rising edge.
   // Checks acceptance and strobe before the edge, response right after.
   task automatic do_req(input string tag, input logic rd, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic exp_we, input logic [31:0] exp_rdata, input logic exp_err);
      cmd_valid    = 1'b1;
      cmd_read     = rd;
      cmd_addr     = addr;
      cmd_size     = size;
      cmd_unsigned = uns;
      cmd_wdata    = wdata;
      @(negedge clk);
      chk({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
      chk({tag, "_we"},  {31'd0, ram_we},    {31'd0, exp_we});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk({tag, "_vld"},  {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_data"}, rsp_rdata,          exp_rdata);
      chk({tag, "_err"},  {31'd0, rsp_err},   {31'd0, exp_err});
   endtask

   initial begin
      rst          = 1'b1;
      rsp_ready    = 1'b1;
      cmd_valid    = 1'b1;
      cmd_read     = 1'b0;
      cmd_addr     = 32'h00000000;
      cmd_size     = 2'd2;
      cmd_unsigned = 1'b0;
      cmd_wdata    = 32'hFFFFFFFF;

      // Reset state, with a store request held present during reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata,          32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
      cmd_valid = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;

      // Word store then load
      cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h10; cmd_size = 2'd2; cmd_wdata = 32'hDEADBEEF;
      #1;
      chk("stw_wem",  {28'd0, ram_wem}, 32'h0000000F);
      chk("stw_addr", ram_addr,         32'h00000004);
      do_req("stw",  1'b0, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0);
      do_req("ldw",  1'b1, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);

      // Byte store and signed/unsigned byte loads
      cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h13; cmd_size = 2'd0; cmd_wdata = 32'h00000080;
      #1;
      chk("stb_wem", {28'd0, ram_wem}, 32'h00000008);
      chk("stb_din", ram_din,          32'h80808080);
      do_req("stb",  1'b0, 32'h13, 2'd0, 1'b0, 32'h00000080, 1'b1, 32'h00000000, 1'b0);
      do_req("ldbs", 1'b1, 32'h13, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0);
      do_req("ldbu", 1'b1, 32'h13, 2'd0, 1'b1, 32'h0, 1'b0, 32'h00000080, 1'b0);
      do_req("ldw2", 1'b1, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h80ADBEEF, 1'b0);

      // Back-to-back loads with a 3-cycle stall after the first response
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0; cmd_size = 2'd2; cmd_unsigned = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b0_vld",  {31'd0, rsp_valid}, 32'd1);
      chk("b2b0_data", rsp_rdata, 32'h11223344);
      rsp_ready = 1'b0;
      cmd_addr  = 32'h4;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_vld",  {31'd0, rsp_valid}, 32'd1);
         chk("stall_data", rsp_rdata,          32'h11223344);
         chk("stall_err",  {31'd0, rsp_err},   32'd0);
         chk("stall_rdy",  {31'd0, cmd_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("unstall_rdy",  {31'd0, cmd_ready}, 32'd1);
      chk("unstall_data", rsp_rdata,          32'h11223344);
      @(posedge clk);
      #1;
      chk("b2b1_data", rsp_rdata, 32'h55667788);
      cmd_addr = 32'h8;
      @(posedge clk);
      #1;
      chk("b2b2_data", rsp_rdata, 32'h99AABBCC);
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_idle", {31'd0, rsp_valid}, 32'd0);

      // Range and size errors; last valid word just below the boundary
      do_req("ld_top", 1'b1, 32'h7FC, 2'd2, 1'b0, 32'h0, 1'b0, 32'hC0DE01FF, 1'b0);
      do_req("ld_oor", 1'b1, 32'h800, 2'd2, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b1);
      do_req("st_oor", 1'b0, 32'h800, 2'd2, 1'b0, 32'h12345678, 1'b0, 32'h00000000, 1'b1);
      do_req("ld_sz3", 1'b1, 32'h000, 2'd3, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b1);

      // Misaligned half store
`ifdef DTCM_CTRL_ALIGN_CHK_EN
      do_req("sth21", 1'b0, 32'h21, 2'd1, 1'b0, 32'h0000ABCD, 1'b0, 32'h00000000, 1'b1);
      do_req("ldw20", 1'b1, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 32'hC0DE0008, 1'b0);
`else
      do_req("sth21", 1'b0, 32'h21, 2'd1, 1'b0, 32'h0000ABCD, 1'b1, 32'h00000000, 1'b0);
      do_req("ldw20", 1'b1, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 32'hC0DEABCD, 1'b0);
`endif
      do_req("ldhs22", 1'b1, 32'h22, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFFC0DE, 1'b0);
      do_req("ldhu22", 1'b1, 32'h22, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0000C0DE, 1'b0);

      // Reset while a fresh load response is pending
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h10; cmd_size = 2'd2;
      @(posedge clk);
      #1;
      chk("mid_vld", {31'd0, rsp_valid}, 32'd1);
      chk("mid_data", rsp_rdata, 32'h80ADBEEF);
      cmd_read = 1'b0; cmd_addr = 32'h30; cmd_wdata = 32'hFFFFFFFF;
      rst = 1'b1;
      #1;
      chk("midrst_vld",  {31'd0, rsp_valid}, 32'd0);
      chk("midrst_rdy",  {31'd0, cmd_ready}, 32'd0);
      chk("midrst_we",   {31'd0, ram_we},    32'd0);
      chk("midrst_data", rsp_rdata,          32'd0);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;
      do_req("post_ld30", 1'b1, 32'h30, 2'd2, 1'b0, 32'h0, 1'b0, 32'hC0DE000C, 1'b0);
      do_req("post_ld10", 1'b1, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h80ADBEEF, 1'b0);

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
